// File: rtl/ucl_param.sv
// ucl_param: WIDTH-bit up/down counter with programmable modulus, clear, load, wrap/saturate and carry pulse.
// Optional sticky overflow output enabled by defining UCL_OVF_STICKY_EN.
module ucl_param #(
   parameter int     WIDTH    = 8,
   parameter longint MODULO   = longint'(64'd1) << WIDTH,
   parameter int     SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic             en,
   input  logic             up,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             carry
`ifdef UCL_OVF_STICKY_EN
   ,
   output logic             ovf
`endif
);

   localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MODULO - 64'd1);
   localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] count_q, count_d;
   logic             carry_q, carry_d;

   // Next-state: clr > load > en > hold; range ends wrap or hold depending on SATURATE.
   always_comb begin
      count_d = count_q;
      carry_d = 1'b0;
      if (clr) begin
         count_d = ZERO_C;
      end else if (load) begin
         count_d = (d > MAX_C) ? MAX_C : d;
      end else if (en) begin
         if (up) begin
            if (count_q == MAX_C) begin
               carry_d = 1'b1;
               count_d = (SATURATE != 0) ? count_q : ZERO_C;
            end else begin
               count_d = count_q + ONE_C;
            end
         end else begin
            if (count_q == ZERO_C) begin
               carry_d = 1'b1;
               count_d = (SATURATE != 0) ? count_q : MAX_C;
            end else begin
               count_d = count_q - ONE_C;
            end
         end
      end else begin
         count_d = count_q;
      end
   end

   // Count and carry registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= ZERO_C;
         carry_q <= 1'b0;
      end else begin
         count_q <= count_d;
         carry_q <= carry_d;
      end
   end

   // Terminal count tracks the live direction input.
   always_comb begin
      if (up) begin
         tc = (count_q == MAX_C);
      end else begin
         tc = (count_q == ZERO_C);
      end
   end

   assign count = count_q;
   assign carry = carry_q;

`ifdef UCL_OVF_STICKY_EN
   logic ovf_q, ovf_d;

   // Sticky flag: only clear (or reset) drops it; load leaves it alone.
   always_comb begin
      if (clr) begin
         ovf_d = 1'b0;
      end else if (carry_d) begin
         ovf_d = 1'b1;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // Overflow register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_ucl_param.sv
// Table-driven bench for ucl_param: wrap and saturate instances (WIDTH=4, MODULO=10) plus a default-parameter instance.
module tb_ucl_param;

   logic       clk, rst, clr, load, en, up;
   logic [7:0] d8;
   logic [3:0] d4;
   logic [3:0] cnt_w, cnt_s;
   logic [7:0] cnt_d;
   logic       tc_w, tc_s, tc_d, cy_w, cy_s, cy_d;
   int         total, bad;

   assign d4 = d8[3:0];

   ucl_param #(.WIDTH(4), .MODULO(10), .SATURATE(0)) dut_w (
      .clk(clk), .rst(rst), .clr(clr), .load(load), .en(en), .up(up), .d(d4),
      .count(cnt_w), .tc(tc_w), .carry(cy_w)
`ifdef UCL_OVF_STICKY_EN
      , .ovf()
`endif
   );

   ucl_param #(.WIDTH(4), .MODULO(10), .SATURATE(1)) dut_s (
      .clk(clk), .rst(rst), .clr(clr), .load(load), .en(en), .up(up), .d(d4),
      .count(cnt_s), .tc(tc_s), .carry(cy_s)
`ifdef UCL_OVF_STICKY_EN
      , .ovf()
`endif
   );

`ifdef UCL_OVF_STICKY_EN
   logic ovf_d;
`endif

   ucl_param dut_d (
      .clk(clk), .rst(rst), .clr(clr), .load(load), .en(en), .up(up), .d(d8),
      .count(cnt_d), .tc(tc_d), .carry(cy_d)
`ifdef UCL_OVF_STICKY_EN
      , .ovf(ovf_d)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       clr, load, en, up;
      logic [3:0] d;
      logic [3:0] w_cnt;
      logic       w_tc, w_cy;
      logic [3:0] s_cnt;
      logic       s_tc, s_cy;
   } vec_t;

   vec_t tbl [21];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0; bad = 0;
      //            clr   load  en    up    d      w_cnt  wtc   wcy   s_cnt  stc   scy
      tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd8,  4'd8, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd9, 1'b1, 1'b0, 4'd9, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd0, 1'b0, 1'b1, 4'd9, 1'b1, 1'b1};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd1, 1'b0, 1'b0, 4'd9, 1'b1, 1'b1};
      tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd1,  4'd1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd9, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd8, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd14, 4'd9, 1'b1, 1'b0, 4'd9, 1'b1, 1'b0};
      tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd3,  4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd9,  4'd9, 1'b1, 1'b0, 4'd9, 1'b1, 1'b0};
      tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd8, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0};
      tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd9,  4'd9, 1'b1, 1'b0, 4'd9, 1'b1, 1'b0};
      tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd0, 1'b0, 1'b1, 4'd9, 1'b1, 1'b1};
      tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd1, 1'b0, 1'b0, 4'd9, 1'b1, 1'b1};
      tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd2, 1'b0, 1'b0, 4'd9, 1'b1, 1'b1};
      tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd1, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0};
      tbl[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd9,  4'd9, 1'b1, 1'b0, 4'd9, 1'b1, 1'b0};
      tbl[19] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd0, 1'b0, 1'b1, 4'd9, 1'b1, 1'b1};
      tbl[20] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd0,  4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};

      rst = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; d8 = 8'd0;
      #12;
      chk("rst_cnt_w", 32'(cnt_w), 32'd0);
      chk("rst_cy_w", 32'(cy_w), 32'd0);
      chk("rst_tc_up", 32'(tc_w), 32'd0);
      up = 1'b0;
      #1;
      chk("rst_tc_dn", 32'(tc_w), 32'd1);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 21; i++) begin
         clr = tbl[i].clr; load = tbl[i].load; en = tbl[i].en; up = tbl[i].up;
         d8 = {4'd0, tbl[i].d};
         step();
         chk($sformatf("v%0d_cnt_w", i), 32'(cnt_w), 32'(tbl[i].w_cnt));
         chk($sformatf("v%0d_tc_w", i),  32'(tc_w),  32'(tbl[i].w_tc));
         chk($sformatf("v%0d_cy_w", i),  32'(cy_w),  32'(tbl[i].w_cy));
         chk($sformatf("v%0d_cnt_s", i), 32'(cnt_s), 32'(tbl[i].s_cnt));
         chk($sformatf("v%0d_tc_s", i),  32'(tc_s),  32'(tbl[i].s_tc));
         chk($sformatf("v%0d_cy_s", i),  32'(cy_s),  32'(tbl[i].s_cy));
      end

      // Asynchronous reset mid-count, then first step after release.
      clr = 1'b0; load = 1'b1; en = 1'b0; up = 1'b1; d8 = 8'd5;
      step();
      chk("mid_cnt_w", 32'(cnt_w), 32'd5);
      #2;
      rst = 1'b0;
      #1;
      chk("async_cnt_w", 32'(cnt_w), 32'd0);
      chk("async_cnt_s", 32'(cnt_s), 32'd0);
      chk("async_cnt_d", 32'(cnt_d), 32'd0);
      chk("async_cy_w", 32'(cy_w), 32'd0);
`ifdef UCL_OVF_STICKY_EN
      chk("async_ovf", 32'(ovf_d), 32'd0);
`endif
      load = 1'b0; en = 1'b1; up = 1'b1;
      @(negedge clk);
      chk("held_cnt_w", 32'(cnt_w), 32'd0);
      rst = 1'b1;
      step();
      chk("post_rst_cnt_w", 32'(cnt_w), 32'd1);

      // Default parameters: 255 -> 0 wrap with carry and sticky overflow.
      load = 1'b1; en = 1'b0; d8 = 8'd255;
      step();
      chk("d_load_cnt", 32'(cnt_d), 32'd255);
      chk("d_load_tc", 32'(tc_d), 32'd1);
      load = 1'b0; en = 1'b1;
      step();
      chk("d_wrap_cnt", 32'(cnt_d), 32'd0);
      chk("d_wrap_cy", 32'(cy_d), 32'd1);
`ifdef UCL_OVF_STICKY_EN
      chk("d_wrap_ovf", 32'(ovf_d), 32'd1);
`endif
      step();
      chk("d_next_cnt", 32'(cnt_d), 32'd1);
      chk("d_next_cy", 32'(cy_d), 32'd0);
`ifdef UCL_OVF_STICKY_EN
      chk("d_next_ovf", 32'(ovf_d), 32'd1);
`endif
      load = 1'b1; en = 1'b0; d8 = 8'd7;
      step();
      chk("d_ld7_cnt", 32'(cnt_d), 32'd7);
`ifdef UCL_OVF_STICKY_EN
      chk("d_ld7_ovf", 32'(ovf_d), 32'd1);
`endif
      clr = 1'b1; load = 1'b0;
      step();
      chk("d_clr_cnt", 32'(cnt_d), 32'd0);
`ifdef UCL_OVF_STICKY_EN
      chk("d_clr_ovf", 32'(ovf_d), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ucl_param.md
# ucl_param

Parametrised successor to the 4-bit loadable up-counter. Provides a WIDTH-bit up/down counter with programmable modulus, synchronous clear, parallel load, count enable, wrap or saturate mode, terminal-count flag and registered carry/borrow pulse. Used as the general-purpose counter primitive for timers, dividers and sequencers across the design; the 4-bit loadable counter is the special case WIDTH=4, MODULO=16, SATURATE=0, up=1, en=1.

## Interface
- WIDTH, 8: counter width in bits (2..32).
- MODULO, 2**WIDTH: count range 0..MODULO-1; must satisfy 2 <= MODULO <= 2**WIDTH.
- SATURATE, 0: 0 = wrap at range ends; 1 = hold at range ends.

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset; asserted low clears all state immediately, released synchronously by the system.
- clr  in  1  synchronous clear to 0.
- load  in  1  synchronous parallel load of d.
- en  in  1  count enable.
- up  in  1  direction: 1 = increment, 0 = decrement.
- d  in  WIDTH  load value.
- count  out  WIDTH  current count (registered).
- tc  out  1  terminal count: combinational, high when count == MODULO-1 with up=1, or count == 0 with up=0.
- carry  out  1  registered one-cycle pulse marking a wrap (or blocked step in saturate mode).
- ovf  out  1  sticky overflow flag; present only with UCL_OVF_STICKY_EN.

## Operation
- Priority per rising edge: clr > load > en > hold.
- clr=1: count <= 0; carry <= 0; ovf <= 0.
- load=1 (clr=0): count <= d if d <= MODULO-1, else count <= MODULO-1 (clamp); carry <= 0; en and up ignored.
- en=1, up=1: count < MODULO-1 -> count+1; count == MODULO-1 -> 0 (SATURATE=0) or hold (SATURATE=1); carry <= 1 in the terminal case.
- en=1, up=0: count > 0 -> count-1; count == 0 -> MODULO-1 (SATURATE=0) or hold (SATURATE=1); carry <= 1 in the terminal case.
- en=0, no clr/load: count holds; carry <= 0.
- carry is high for exactly one cycle per terminal event; back-to-back terminal events (e.g. MODULO=2 counting continuously, or saturate holding with en=1) give carry high on consecutive cycles.
- Arithmetic is modulo MODULO, never modulo 2**WIDTH; count never leaves 0..MODULO-1.
- Direction change takes effect on the same edge it is sampled; tc follows up combinationally.

## Timing
- Reset (rst=0): count=0, carry=0, ovf=0 immediately, independent of clk; tc = (up==0) while reset held.
- Load, clear, step latency: 1 cycle (new count visible after the sampling edge).
- carry asserted in the cycle following the edge that caused the terminal event, coinciding with the wrapped/held count.
- rst asserted mid-count: all outputs to reset values asynchronously; first step after release counts from 0.
- clr and load asserted together: clr wins, count=0.

## Configuration
- UCL_OVF_STICKY_EN defined: ovf port exists; set to 1 on the edge that sets carry, remains 1 until clr=1 or rst=0; load does not clear it.
- Not defined: no ovf port and no associated flop; all other behaviour identical.

## Test plan
- Reset: drive rst=0 mid-count at count=5 -> count=0, carry=0, ovf=0 immediately without a clock edge.
- Wrap up, WIDTH=4, MODULO=10, SATURATE=0: load 8, en=1, up=1 -> count 9, 0, 1; tc high at 9; carry high for exactly the cycle count=0.
- Wrap down, same config: load 1, up=0 -> count 0, 9, 8; carry pulses with count=9; tc high at 0.
- Saturate, MODULO=10, SATURATE=1: load 9, up=1, en=1 for 3 cycles -> count stays 9, carry high each cycle; then up=0 -> 8.
- Load clamp and priority: d=14 with MODULO=10, load=1 -> count=9; clr=1 and load=1 with d=3 -> count=0; en=0 -> count holds.
- With UCL_OVF_STICKY_EN, default params: load 255, up=1, en=1 -> count=0, ovf=1; further counting and a load keep ovf=1; clr=1 -> ovf=0.
